// File: rtl/rc_ctu_dispatch.sv
// Per-CTU dispatcher for the rate-control unit: pairs CABAC bit counts with pre-I costs in
// raster order, launches rate control per CTU and queues the returned QPs in a small FIFO.
module rc_ctu_dispatch #(
    parameter int X_W     = 7,
    parameter int Y_W     = 6,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sys_start_i,
    output logic           sys_done_o,
    input  logic [X_W-1:0] cfg_ctu_w_i,
    input  logic [Y_W-1:0] cfg_ctu_h_i,
    input  logic [5:0]     cfg_init_qp_i,
    input  logic           cabac_vld_i,
    input  logic [15:0]    cabac_bitnum_i,
    input  logic           prei_vld_i,
    input  logic [27:0]    prei_cost_i,
    output logic           rc_start_o,
    input  logic           rc_done_i,
    input  logic [5:0]     rc_qp_i,
    output logic [X_W-1:0] rc_ctu_x_o,
    output logic [Y_W-1:0] rc_ctu_y_o,
    output logic [15:0]    rc_bitnum_o,
    output logic [27:0]    rc_cost_o,
    output logic           qp_vld_o,
    input  logic           qp_rdy_i,
    output logic [5:0]     qp_o,
    output logic           rc_timeout_o,
    output logic           in_ovf_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_START, S_WAIT, S_DONE} state_t;

    state_t         state_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           cab_pend_q, pre_pend_q;
    logic [15:0]    cab_buf_q, rc_bitnum_q;
    logic [27:0]    pre_buf_q, rc_cost_q;
    logic           rc_start_q, sys_done_q, timeout_q, ovf_q;
    logic [WDW-1:0] wd_q;

    logic [5:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW:0]    count_q, count_d;

    logic [X_W-1:0] x_last;
    logic [Y_W-1:0] y_last;
    logic           active, copy, cab_take, cab_ovf, pre_take, pre_ovf, push, pop;
    logic [5:0]     push_qp;

    // Zero-sized frame dimensions behave like a single CTU.
    assign x_last = (cfg_ctu_w_i == '0) ? '0 : cfg_ctu_w_i - X_W'(1);
    assign y_last = (cfg_ctu_h_i == '0) ? '0 : cfg_ctu_h_i - Y_W'(1);

    assign active   = (state_q == S_COLLECT) || (state_q == S_START) || (state_q == S_WAIT);
    assign copy     = (state_q == S_COLLECT) && cab_pend_q && pre_pend_q && (count_q < FULL_CNT);
    // A copy frees the slot this cycle, so a simultaneous valid is captured rather than dropped.
    assign cab_take = active && cabac_vld_i && (!cab_pend_q || copy);
    assign cab_ovf  = active && cabac_vld_i && cab_pend_q && !copy;
    assign pre_take = active && prei_vld_i && (!pre_pend_q || copy);
    assign pre_ovf  = active && prei_vld_i && pre_pend_q && !copy;
    assign push     = (state_q == S_WAIT) && (rc_done_i || (wd_q == WD_LAST));
    assign push_qp  = rc_done_i ? rc_qp_i : cfg_init_qp_i;
    assign pop      = qp_vld_o && qp_rdy_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (PW + 1)'(1);
        else if (pop && !push)
            count_d = count_q - (PW + 1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cab_pend_q  <= 1'b0;
            pre_pend_q  <= 1'b0;
            cab_buf_q   <= '0;
            pre_buf_q   <= '0;
            rc_bitnum_q <= '0;
            rc_cost_q   <= '0;
            rc_start_q  <= 1'b0;
            sys_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            ovf_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            rc_start_q <= 1'b0;
            sys_done_q <= 1'b0;
            if (cab_take) begin
                cab_pend_q <= 1'b1;
                cab_buf_q  <= cabac_bitnum_i;
            end else if (copy) begin
                cab_pend_q <= 1'b0;
            end
            if (pre_take) begin
                pre_pend_q <= 1'b1;
                pre_buf_q  <= prei_cost_i;
            end else if (copy) begin
                pre_pend_q <= 1'b0;
            end
            if (cab_ovf || pre_ovf)
                ovf_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (sys_start_i) begin
                        x_q        <= '0;
                        y_q        <= '0;
                        cab_pend_q <= 1'b0;
                        pre_pend_q <= 1'b0;
                        timeout_q  <= 1'b0;
                        ovf_q      <= 1'b0;
                        state_q    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (copy) begin
                        rc_bitnum_q <= cab_buf_q;
                        rc_cost_q   <= pre_buf_q;
                        rc_start_q  <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (push) begin
                        if (!rc_done_i)
                            timeout_q <= 1'b1;
                        if (x_q < x_last) begin
                            x_q     <= x_q + X_W'(1);
                            state_q <= S_COLLECT;
                        end else begin
                            x_q <= '0;
                            if (y_q < y_last) begin
                                y_q     <= y_q + Y_W'(1);
                                state_q <= S_COLLECT;
                            end else begin
                                sys_done_q <= 1'b1;
                                state_q    <= S_DONE;
                            end
                        end
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= push_qp;
    end

    assign qp_vld_o     = (count_q != '0);
    assign qp_o         = qp_vld_o ? mem[rd_ptr_q] : '0;
    assign rc_start_o   = rc_start_q;
    assign sys_done_o   = sys_done_q;
    assign rc_ctu_x_o   = x_q;
    assign rc_ctu_y_o   = y_q;
    assign rc_bitnum_o  = rc_bitnum_q;
    assign rc_cost_o    = rc_cost_q;
    assign rc_timeout_o = timeout_q;
    assign in_ovf_o     = ovf_q;

endmodule
